full_add_sub: RTL and testbench

// - Registered WIDTH-bit ripple adder/subtractor; one fas_bit cell per bit position.
// - a_ns selects the operation: 1 = add (a+b+cin), 0 = subtract (a + ~b + cin).
// - Two's-complement subtract a-b is performed with a_ns=0, cin=1.
// - Arithmetic leaf used by datapath/ALU blocks; at WIDTH=1 it is the classic

---
 rtl/fas_pkg.sv | 35 +++
 rtl/fas_bit.sv | 18 +
 rtl/full_add_sub.sv | 51 +++++
 tb/tb_full_add_sub.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared constants and a behavioural reference for the ripple adder/subtractor.
// The reference is word-level arithmetic, independent of the bit-cell chain.
package fas_pkg;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    localparam int FAS_MAX_W = 64;

    typedef logic [FAS_MAX_W-1:0] fas_word_t;
    typedef logic [FAS_MAX_W:0]   fas_res_t;

    // Returns {cout, s} in the low width+1 bits; upper bits are zero.
    function automatic fas_res_t ref_add_sub(
        input fas_word_t a,
        input fas_word_t b,
        input logic      a_ns,
        input logic      cin,
        input int        width
    );
        fas_word_t mask;
        fas_word_t bb;
        fas_res_t  sum;
        if (width >= FAS_MAX_W)
            mask = '1;
        else
            mask = (fas_word_t'(1) << width) - fas_word_t'(1);
        bb  = (a_ns == OP_ADD) ? b : ~b;
        sum = {1'b0, a & mask}
            + {1'b0, bb & mask}
            + {{FAS_MAX_W{1'b0}}, cin};
        return sum;
    endfunction

endpackage

// File: rtl/fas_bit.sv
// One bit of the adder/subtractor: conditionally inverted B
// feeding a sum XOR and a majority carry.
module fas_bit (
    input  logic a,
    input  logic b,
    input  logic a_ns,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic bb;

    assign bb   = b ^ ~a_ns;
    assign s    = a ^ bb ^ cin;
    assign cout = (a & bb) | (a & cin) | (bb & cin);

endmodule

// File: rtl/full_add_sub.sv
// Registered WIDTH-bit ripple adder/subtractor built from fas_bit cells.
// Sum, carry-out and signed overflow are captured together each cycle.
module full_add_sub
    import fas_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_ns,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_nxt;
    logic             ovf_nxt;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fas_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .a_ns (a_ns),
            .cin  (c[i]),
            .s    (s_nxt[i]),
            .cout (c[i+1])
        );
    end

    // At WIDTH=1 the carry into the MSB is cin itself.
    assign ovf_nxt = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            s    <= s_nxt;
            cout <= c[WIDTH];
            ovf  <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_full_add_sub.sv
// Directed and random checks of full_add_sub at WIDTH 1, 8 and 16.
// Each result is compared one clock after its inputs were applied.
module tb_full_add_sub;
    import fas_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic       a1, b1, ns1, ci1, s1, co1, ov1;
    logic [7:0] a8, b8, s8;
    logic       ns8, ci8, co8, ov8;
    logic [15:0] a16, b16, s16;
    logic        ns16, ci16, co16, ov16;

    int n_cmp = 0;
    int n_bad = 0;

    fas_res_t   r;
    logic [15:0] bb16;
    logic        e_ov;

    always #5 clk = ~clk;

    full_add_sub #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .a_ns(ns1), .cin(ci1),
        .s(s1), .cout(co1), .ovf(ov1)
    );

    full_add_sub #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .a_ns(ns8), .cin(ci8),
        .s(s8), .cout(co8), .ovf(ov8)
    );

    full_add_sub #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .a_ns(ns16), .cin(ci16),
        .s(s16), .cout(co16), .ovf(ov16)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] es,
                        input logic eco, input logic eov);
        chk({tag, ".s"}, 64'(s8), 64'(es));
        chk({tag, ".cout"}, 64'(co8), 64'(eco));
        chk({tag, ".ovf"}, 64'(ov8), 64'(eov));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; ns1 = 1'b1; ci1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; ns8 = 1'b1; ci8 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; ns16 = 1'b1; ci16 = 1'b1;

        // Outputs cleared before any clock edge.
        #2;
        chk("rst0.s1", 64'(s1), 64'd0);
        chk("rst0.s8", 64'(s8), 64'd0);
        chk("rst0.co8", 64'(co8), 64'd0);
        chk("rst0.ov8", 64'(ov8), 64'd0);
        chk("rst0.s16", 64'(s16), 64'd0);

        repeat (2) tick();
        chk("rsthold.s8", 64'(s8), 64'd0);
        chk("rsthold.co8", 64'(co8), 64'd0);
        chk("rsthold.s16", 64'(s16), 64'd0);
        rst = 1'b0;

        // WIDTH=1 directed sequence
        a1 = 1'b0; b1 = 1'b0; ci1 = 1'b1; ns1 = 1'b1;
        tick();
        chk("w1.add.s", 64'(s1), 64'd1);
        chk("w1.add.cout", 64'(co1), 64'd0);
        chk("w1.add.ovf", 64'(ov1), 64'd1);
        ns1 = 1'b0;
        tick();
        chk("w1.sub.s", 64'(s1), 64'd0);
        chk("w1.sub.cout", 64'(co1), 64'd1);
        chk("w1.sub.ovf", 64'(ov1), 64'd0);
        ns1 = 1'b1;
        tick();
        chk("w1.add2.s", 64'(s1), 64'd1);
        chk("w1.add2.cout", 64'(co1), 64'd0);

        // WIDTH=1 exhaustive
        for (int k = 0; k < 16; k++) begin
            {a1, b1, ci1, ns1} = 4'(k);
            r = ref_add_sub(64'(a1), 64'(b1), ns1, ci1, 1);
            tick();
            chk($sformatf("w1.ex%0d.s", k), 64'(s1), 64'(r[0]));
            chk($sformatf("w1.ex%0d.cout", k), 64'(co1), 64'(r[1]));
            chk($sformatf("w1.ex%0d.ovf", k), 64'(ov1), 64'(r[1] ^ ci1));
        end

        // WIDTH=8 add
        a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; ns8 = OP_ADD;
        tick();
        chk8("w8.ff+1", 8'h00, 1'b1, 1'b0);
        a8 = 8'h7F;
        tick();
        chk8("w8.7f+1", 8'h80, 1'b0, 1'b1);

        // WIDTH=8 subtract
        ns8 = OP_SUB; ci8 = 1'b1;
        a8 = 8'h05; b8 = 8'h03;
        tick();
        chk8("w8.5-3", 8'h02, 1'b1, 1'b0);
        a8 = 8'h03; b8 = 8'h05;
        tick();
        chk8("w8.3-5", 8'hFE, 1'b0, 1'b0);
        a8 = 8'h5A; b8 = 8'h5A;
        tick();
        chk8("w8.eq", 8'h00, 1'b1, 1'b0);
        a8 = 8'h80; b8 = 8'h01;
        tick();
        chk8("w8.80-1", 8'h7F, 1'b1, 1'b1);

        // Async reset between edges, then hold with clock running.
        #2;
        rst = 1'b1;
        a8 = 8'h10; b8 = 8'h20; ns8 = OP_ADD; ci8 = 1'b0;
        #1;
        chk8("w8.arst", 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        chk8("w8.arsthold", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk8("w8.postrst", 8'h30, 1'b0, 1'b0);

        // WIDTH=16 back-to-back random
        for (int k = 0; k < 1000; k++) begin
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            ns16 = 1'($urandom);
            ci16 = 1'($urandom);
            r    = ref_add_sub(64'(a16), 64'(b16), ns16, ci16, 16);
            bb16 = ns16 ? b16 : ~b16;
            e_ov = (a16[15] == bb16[15]) && (r[15] != a16[15]);
            tick();
            chk("w16.s", 64'(s16), 64'(r[15:0]));
            chk("w16.cout", 64'(co16), 64'(r[16]));
            chk("w16.ovf", 64'(ov16), 64'(e_ov));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
